// File: rtl/seg7_scan_driver_pkg.sv
// Shared segment encodings and scan-phase type for the 7-segment scan driver.
// Patterns are {g,f,e,d,c,b,a}, active-high, matching the bcd_to_7seg encoding.
package seg7_scan_driver_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_ZERO  = 7'h3F;
  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot prescaler and digit index for the scan driver; also flags slot/frame ends
// and whether the current slot is still in its anti-ghosting blank gap.
module seg7_scan_timer
  import seg7_scan_driver_pkg::*;
#(
  parameter int NumDig      = 4,
  parameter int RefreshDiv  = 50000,
  parameter int BlankCycles = 64,
  parameter int IdxW        = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [IdxW-1:0] idx,
  output logic [IdxW-1:0] next_idx,
  output logic            slot_end,
  output logic            frame_end,
  output phase_e          phase
);

  localparam int PreW = (RefreshDiv > 1) ? $clog2(RefreshDiv) : 1;
  localparam logic [PreW-1:0] PreLast  = PreW'(RefreshDiv - 1);
  localparam logic [PreW-1:0] BlankEnd = PreW'(BlankCycles);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumDig - 1);

  logic [PreW-1:0] presc;

  assign slot_end  = (presc == PreLast);
  assign frame_end = slot_end && (idx == IdxLast);
  assign next_idx  = (idx == IdxLast) ? '0 : idx + IdxW'(1);
  assign phase     = (presc < BlankEnd) ? PH_BLANK : PH_DRIVE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (slot_end) begin
      presc <= '0;
      idx   <= next_idx;
    end else begin
      presc <= presc + PreW'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: captures a packed segment word on each valid
// strobe, scans digits with a blank gap, leading-zero blanking and a stale watchdog.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int NumDig      = 4,
  parameter int RefreshDiv  = 50000,
  parameter int BlankCycles = 64,
  parameter int StaleLimit  = 150000000,
  parameter int BlankLeadZ  = 1,
  parameter int SegActLow   = 1,
  parameter int AnActLow    = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NumDig*7-1:0]       i_seg_data,
  input  logic                      i_seg_valid,
  output logic [6:0]                o_seg,
  output logic [NumDig-1:0]         o_an,
  output logic [$clog2(NumDig)-1:0] o_digit_idx,
  output logic                      o_frame_done,
  output logic                      o_stale
);

  localparam int IdxW = $clog2(NumDig);
  localparam int WdW  = $clog2(StaleLimit) + 1;
  localparam logic [WdW-1:0]    WdLast = WdW'(StaleLimit - 1);
  localparam logic [NumDig-1:0] AnOff  = (AnActLow != 0) ? '1 : '0;
  localparam logic [6:0]        SegOff = (SegActLow != 0) ? 7'h7F : 7'h00;

  logic [IdxW-1:0]     idx;
  logic [IdxW-1:0]     next_idx;
  logic                slot_end;
  logic                frame_end;
  phase_e              phase;

  logic [NumDig*7-1:0] cap;
  logic [WdW-1:0]      wd;
  logic [NumDig-1:0]   lz_blank;
  logic                above_zero;
  seg_t                next_pat;
  seg_t                slot_pat;
  logic [NumDig-1:0]   an_raw;
  seg_t                seg_raw;

  seg7_scan_timer #(
    .NumDig      (NumDig),
    .RefreshDiv  (RefreshDiv),
    .BlankCycles (BlankCycles),
    .IdxW        (IdxW)
  ) u_timer (
    .clk       (i_clk),
    .rst       (i_rst),
    .idx       (idx),
    .next_idx  (next_idx),
    .slot_end  (slot_end),
    .frame_end (frame_end),
    .phase     (phase)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cap <= {NumDig{SEG_BLANK}};
    end else if (i_seg_valid) begin
      cap <= i_seg_data;
    end
  end

  // A fresh strobe always beats the watchdog reaching its limit in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd      <= '0;
      o_stale <= 1'b0;
    end else if (i_seg_valid) begin
      wd      <= '0;
      o_stale <= 1'b0;
    end else if (!o_stale) begin
      if (wd == WdLast) begin
        o_stale <= 1'b1;
      end else begin
        wd <= wd + WdW'(1);
      end
    end
  end

  // A digit is a leading zero when it and every digit above it show SEG_ZERO.
  always_comb begin
    lz_blank   = '0;
    above_zero = 1'b1;
    for (int k = NumDig - 1; k >= 1; k--) begin
      above_zero  = above_zero && (cap[k*7 +: 7] == SEG_ZERO);
      lz_blank[k] = above_zero && (BlankLeadZ != 0);
    end
  end

  always_comb begin
    next_pat = cap[int'(next_idx)*7 +: 7];
    if (o_stale) begin
      next_pat = SEG_DASH;
    end else if (lz_blank[next_idx]) begin
      next_pat = SEG_BLANK;
    end
  end

  // The pattern is latched at the slot boundary so new data never glitches a slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_pat <= SEG_BLANK;
    end else if (slot_end) begin
      slot_pat <= next_pat;
    end
  end

  always_comb begin
    an_raw  = '0;
    seg_raw = SEG_BLANK;
    if (phase == PH_DRIVE) begin
      an_raw  = NumDig'(1) << idx;
      seg_raw = slot_pat;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_an         <= AnOff;
      o_seg        <= SegOff;
      o_digit_idx  <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_an         <= (AnActLow != 0) ? ~an_raw : an_raw;
      o_seg        <= (SegActLow != 0) ? ~seg_raw : seg_raw;
      o_digit_idx  <= idx;
      o_frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with short refresh/stale timing; all outputs
// are sampled on the falling edge and compared against hand-computed patterns.
module tb_seg7_scan_driver;

  localparam int NumDig      = 4;
  localparam int RefreshDiv  = 8;
  localparam int BlankCycles = 2;
  localparam int StaleLimit  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [27:0] data = '0;
  logic        valid = 1'b0;
  logic [6:0]  o_seg;
  logic [3:0]  o_an;
  logic [1:0]  o_digit_idx;
  logic        o_frame_done;
  logic        o_stale;

  int errors = 0;
  int checks = 0;

  // Digit patterns {d3,d2,d1,d0} and the inverted o_seg expected per digit.
  localparam logic [27:0] D1234 = {7'h06, 7'h5B, 7'h4F, 7'h66};
  localparam logic [27:0] E1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] D0007 = {7'h3F, 7'h3F, 7'h3F, 7'h07};
  localparam logic [27:0] E0007 = {7'h7F, 7'h7F, 7'h7F, 7'h78};
  localparam logic [27:0] D0000 = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
  localparam logic [27:0] E0000 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] D0100 = {7'h3F, 7'h06, 7'h3F, 7'h3F};
  localparam logic [27:0] E0100 = {7'h7F, 7'h79, 7'h40, 7'h40};
  localparam logic [27:0] EDASH = {7'h3F, 7'h3F, 7'h3F, 7'h3F};

  seg7_scan_driver #(
    .NumDig      (NumDig),
    .RefreshDiv  (RefreshDiv),
    .BlankCycles (BlankCycles),
    .StaleLimit  (StaleLimit),
    .BlankLeadZ  (1),
    .SegActLow   (1),
    .AnActLow    (1)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_seg_data   (data),
    .i_seg_valid  (valid),
    .o_seg        (o_seg),
    .o_an         (o_an),
    .o_digit_idx  (o_digit_idx),
    .o_frame_done (o_frame_done),
    .o_stale      (o_stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_valid(input logic [27:0] d);
    data  = d;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (o_frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_frame_seen"}, 32'(n < 100), 32'd1);
  endtask

  task automatic wait_drive(input int k, input string tag);
    int n;
    logic [1:0] kk;
    kk = k[1:0];
    n  = 0;
    @(negedge clk);
    while (!(o_digit_idx === kk && o_an !== 4'hF) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s_drive%0d_seen", tag, k), 32'(n < 100), 32'd1);
  endtask

  task automatic check_digits(input string tag, input logic [27:0] exp);
    logic [3:0] an_exp;
    for (int k = 0; k < NumDig; k++) begin
      wait_drive(k, tag);
      an_exp = ~(4'b0001 << k);
      chk($sformatf("%s_an%0d", tag, k), 32'(o_an), 32'(an_exp));
      chk($sformatf("%s_seg%0d", tag, k), 32'(o_seg), 32'(exp[k*7 +: 7]));
    end
  endtask

  task automatic show_frame(input string tag, input logic [27:0] d, input logic [27:0] exp);
    pulse_valid(d);
    chk({tag, "_stale_clr"}, 32'(o_stale), 32'd0);
    wait_frame(tag);
    check_digits(tag, exp);
  endtask

  initial begin
    int n;

    // Reset held, then released.
    tick(3);
    chk("rst_an", 32'(o_an), 32'hF);
    chk("rst_seg", 32'(o_seg), 32'h7F);
    chk("rst_idx", 32'(o_digit_idx), 32'd0);
    chk("rst_frame", 32'(o_frame_done), 32'd0);
    chk("rst_stale", 32'(o_stale), 32'd0);
    rst = 1'b0;
    wait_drive(0, "boot");
    chk("boot_an0", 32'(o_an), 32'hE);
    chk("boot_seg0", 32'(o_seg), 32'h7F);

    // Plain digits 1,2,3,4 plus blank-gap and frame-period timing.
    show_frame("v1234", D1234, E1234);
    wait_frame("gap");
    tick(1);
    chk("gap_an_c1", 32'(o_an), 32'hF);
    chk("gap_idx_c1", 32'(o_digit_idx), 32'd0);
    tick(1);
    chk("gap_an_c2", 32'(o_an), 32'hF);
    tick(1);
    chk("gap_an_c3", 32'(o_an), 32'hE);
    wait_frame("period");
    n = 0;
    @(negedge clk);
    n++;
    while (o_frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("frame_period", 32'(n), 32'd32);

    // Leading-zero blanking.
    show_frame("v0007", D0007, E0007);
    show_frame("v0000", D0000, E0000);
    show_frame("v0100", D0100, E0100);

    // Watchdog expiry: stale exactly StaleLimit cycles after the capture edge.
    pulse_valid(D0100);
    tick(99);
    chk("stale_before", 32'(o_stale), 32'd0);
    tick(1);
    chk("stale_set", 32'(o_stale), 32'd1);
    wait_frame("dash");
    check_digits("dash", EDASH);
    show_frame("recover", D1234, E1234);

    // Valid in the same cycle the watchdog reaches its limit.
    pulse_valid(D1234);
    tick(99);
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    chk("race_stale0", 32'(o_stale), 32'd0);
    tick(60);
    chk("race_stale60", 32'(o_stale), 32'd0);
    tick(39);
    chk("race_stale99", 32'(o_stale), 32'd0);
    tick(1);
    chk("race_stale100", 32'(o_stale), 32'd1);

    // Reset mid-DRIVE on digit 2.
    pulse_valid(D1234);
    wait_frame("midrst");
    wait_drive(2, "midrst");
    chk("midrst_pre_seg", 32'(o_seg), 32'h24);
    #1 rst = 1'b1;
    #1;
    chk("midrst_an", 32'(o_an), 32'hF);
    chk("midrst_seg", 32'(o_seg), 32'h7F);
    chk("midrst_idx", 32'(o_digit_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    chk("post_an_c1", 32'(o_an), 32'hF);
    tick(1);
    chk("post_an_c2", 32'(o_an), 32'hF);
    tick(1);
    chk("post_an_c3", 32'(o_an), 32'hE);
    chk("post_idx_c3", 32'(o_digit_idx), 32'd0);
    chk("post_seg0", 32'(o_seg), 32'h7F);
    wait_drive(1, "post");
    chk("post_seg1_cleared", 32'(o_seg), 32'h7F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
